crc_nmr_voter: RTL and testbench

N-modular-redundant CRC engine: `p_channels` identical CRC lanes consume one frame each in lock-step, and a bitwise majority voter merges the lane results. Per-lane mismatch tracking, saturating error counters and sticky fault flags are included. It is the parametrised successor of the fixed triple-CRC/majority arrangement, and adds a frame-level valid/ready stream interface and fault bookkeeping. It sits between the redundant data sources and the hash consumer.

---
 rtl/crc_nmr_voter_pkg.sv | 56 +++++
 rtl/crc_nmr_voter_if.sv | 35 +++
 rtl/crc_nmr_voter_lane.sv | 33 +++
 rtl/crc_nmr_voter.sv | 118 +++++++++++
 tb/tb_crc_nmr_voter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/crc_nmr_voter_pkg.sv
// Shared types and combinational helpers for the N-modular-redundant CRC voter.
// Helpers work on MAX_W-bit containers; callers narrow the results with a size cast.
package crc_nmr_pkg;

  localparam int MAX_W  = 32;
  localparam int MAX_CH = 7;

  typedef enum logic [1:0] {ACC, VOTE, HOLD} state_t;

  // Operands are left-aligned so the CRC MSB and the data MSB always sit at bit MAX_W-1.
  function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc,
                                                input logic [MAX_W-1:0] data,
                                                input logic [MAX_W-1:0] poly,
                                                input int w,
                                                input int dw);
    logic [MAX_W-1:0] c;
    logic [MAX_W-1:0] d;
    logic [MAX_W-1:0] p;
    logic             fb;
    c = crc << (MAX_W - w);
    d = data << (MAX_W - dw);
    p = poly << (MAX_W - w);
    for (int i = 0; i < MAX_W; i++) begin
      if (i < dw) begin
        fb = c[MAX_W-1] ^ d[MAX_W-1];
        c  = c << 1;
        d  = d << 1;
        if (fb) c = c ^ p;
      end
    end
    return c >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] majority(input logic [MAX_CH-1:0][MAX_W-1:0] lanes,
                                                input int n);
    logic [MAX_W-1:0] r;
    int               cnt;
    r = '0;
    for (int b = 0; b < MAX_W; b++) begin
      cnt = 0;
      for (int l = 0; l < MAX_CH; l++) begin
        if (l < n) cnt += int'(lanes[l][b]);
      end
      r[b] = (cnt > n / 2);
    end
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_CH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CH; i++) cnt += int'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/crc_nmr_voter_if.sv
// Frame-level stream and status bundle between the redundant sources, the voter and the consumer.
interface crc_nmr_voter_if #(
  parameter int p_channels      = 3,
  parameter int p_width         = 8,
  parameter int p_data_width    = 8,
  parameter int p_err_cnt_width = 8
) ();

  logic                                    in_valid;
  logic                                    in_ready;
  logic                                    in_last;
  logic [p_channels*p_data_width-1:0]      in_data;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [p_width-1:0]                      out_crc;
  logic                                    out_err;
  logic                                    out_uncorrectable;
  logic [p_channels-1:0]                   ch_mismatch;
  logic [p_channels-1:0]                   ch_fault;
  logic [p_channels*p_err_cnt_width-1:0]   err_cnt;
  logic                                    fault_clr;

  modport master (
    output in_valid, in_last, in_data, out_ready, fault_clr,
    input  in_ready, out_valid, out_crc, out_err, out_uncorrectable,
           ch_mismatch, ch_fault, err_cnt
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready, fault_clr,
    output in_ready, out_valid, out_crc, out_err, out_uncorrectable,
           ch_mismatch, ch_fault, err_cnt
  );

endinterface

// File: rtl/crc_nmr_voter_lane.sv
// One CRC lane: a whole data beat is folded into the register per cycle, MSB first.
module crc_lane
  import crc_nmr_pkg::*;
#(
  parameter int                 p_width      = 8,
  parameter logic [p_width-1:0] p_polynom    = 8'h31,
  parameter logic [p_width-1:0] p_init       = 8'hFF,
  parameter int                 p_data_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_adv,
  input  logic [p_data_width-1:0] i_data,
  output logic [p_width-1:0]      o_crc
);

  typedef logic [p_width-1:0] crc_t;

  crc_t r_crc;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_crc <= p_init;
    end else if (i_adv) begin
      r_crc <= crc_t'(crc_step(MAX_W'(r_crc), MAX_W'(i_data), MAX_W'(p_polynom),
                               p_width, p_data_width));
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_nmr_voter.sv
// Lock-step redundant CRC lanes merged by a bitwise majority vote, with per-lane
// mismatch flags, saturating error counters and sticky fault flags.
module crc_nmr_voter
  import crc_nmr_pkg::*;
#(
  parameter int                 p_channels      = 3,
  parameter int                 p_width         = 8,
  parameter logic [p_width-1:0] p_polynom       = 8'h31,
  parameter logic [p_width-1:0] p_init          = 8'hFF,
  parameter int                 p_data_width    = 8,
  parameter int                 p_err_cnt_width = 8,
  parameter int                 p_fault_thresh  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_nmr_voter_if.slave       io_bus
);

  typedef logic [p_width-1:0] crc_t;
  localparam int             CW  = $clog2(p_fault_thresh + 1);
  localparam logic [CW-1:0]  THR = CW'(p_fault_thresh);

  state_t                                    r_state, w_next;
  logic                                      w_accept, w_vote_en, w_load, w_unc;
  logic [p_channels-1:0][p_data_width-1:0]   w_data;
  logic [p_channels-1:0][p_width-1:0]        w_lane_crc;
  logic [MAX_CH-1:0][MAX_W-1:0]              w_lanes_ext;
  crc_t                                      w_vote;
  logic [p_channels-1:0]                     w_mis;

  crc_t                                      r_out_crc;
  logic                                      r_err, r_unc;
  logic [p_channels-1:0]                     r_mis, r_fault;
  logic [p_channels-1:0][p_err_cnt_width-1:0] r_err_cnt;
  logic [p_channels-1:0][CW-1:0]             r_consec;

  assign w_data    = io_bus.in_data;
  assign w_accept  = (r_state == ACC) && io_bus.in_valid;
  assign w_vote_en = (r_state == VOTE);
  assign w_load    = (r_state == HOLD) && io_bus.out_ready;

  for (genvar g = 0; g < p_channels; g++) begin : g_lane
    crc_lane #(
      .p_width(p_width), .p_polynom(p_polynom), .p_init(p_init), .p_data_width(p_data_width)
    ) u_lane (
      .clk(clk), .rst(rst), .i_load(w_load), .i_adv(w_accept),
      .i_data(w_data[g]), .o_crc(w_lane_crc[g])
    );
  end

  always_comb begin
    w_lanes_ext = '0;
    w_mis       = '0;
    for (int i = 0; i < p_channels; i++) w_lanes_ext[i] = MAX_W'(w_lane_crc[i]);
    w_vote = crc_t'(majority(w_lanes_ext, p_channels));
    for (int i = 0; i < p_channels; i++) w_mis[i] = (w_lane_crc[i] != w_vote);
    w_unc = popcount(MAX_CH'(w_mis)) > (p_channels - 1) / 2;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACC:     if (w_accept && io_bus.in_last) w_next = VOTE;
      VOTE:    w_next = HOLD;
      HOLD:    if (io_bus.out_ready) w_next = ACC;
      default: w_next = ACC;
    endcase
  end

  // Result capture and fault bookkeeping: a fault_clr pulse beats a same-cycle vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_crc <= '0;
      r_err     <= 1'b0;
      r_unc     <= 1'b0;
      r_mis     <= '0;
      r_fault   <= '0;
      r_err_cnt <= '0;
      r_consec  <= '0;
    end else begin
      if (w_vote_en) begin
        r_out_crc <= w_vote;
        r_mis     <= w_mis;
        r_err     <= |w_mis;
        r_unc     <= w_unc;
      end
      for (int i = 0; i < p_channels; i++) begin
        if (w_vote_en && w_mis[i] && (r_err_cnt[i] != '1)) r_err_cnt[i] <= r_err_cnt[i] + 1'b1;
        if (io_bus.fault_clr) begin
          r_consec[i] <= '0;
          r_fault[i]  <= 1'b0;
        end else if (w_vote_en) begin
          if (w_mis[i]) begin
            if (r_consec[i] != THR) r_consec[i] <= r_consec[i] + 1'b1;
            if (r_consec[i] >= THR - 1'b1) r_fault[i] <= 1'b1;
          end else begin
            r_consec[i] <= '0;
          end
        end
      end
    end
  end

  assign io_bus.in_ready          = (r_state == ACC);
  assign io_bus.out_valid         = (r_state == HOLD);
  assign io_bus.out_crc           = r_out_crc;
  assign io_bus.out_err           = r_err;
  assign io_bus.out_uncorrectable = r_unc;
  assign io_bus.ch_mismatch       = r_mis;
  assign io_bus.ch_fault          = r_fault;
  assign io_bus.err_cnt           = r_err_cnt;

endmodule

// File: tb/tb_crc_nmr_voter.sv
// Directed bench for crc_nmr_voter: default build plus a zero-preset build for the
// three-way disagreement case.
module tb_crc_nmr_voter;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int DW = 8;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  logic [7:0] msg [9];

  always #5 clk = ~clk;

  crc_nmr_voter_if #(.p_channels(CH), .p_width(W), .p_data_width(DW), .p_err_cnt_width(EW)) b1 ();
  crc_nmr_voter_if #(.p_channels(CH), .p_width(W), .p_data_width(DW), .p_err_cnt_width(EW)) b2 ();

  crc_nmr_voter #(
    .p_channels(CH), .p_width(W), .p_polynom(8'h31), .p_init(8'hFF),
    .p_data_width(DW), .p_err_cnt_width(EW), .p_fault_thresh(4)
  ) dut1 (.clk(clk), .rst(rst), .io_bus(b1.slave));

  crc_nmr_voter #(
    .p_channels(CH), .p_width(W), .p_polynom(8'h31), .p_init(8'h00),
    .p_data_width(DW), .p_err_cnt_width(EW), .p_fault_thresh(4)
  ) dut2 (.clk(clk), .rst(rst), .io_bus(b2.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive nbeats of "123456789"; one lane/beat can be bit-flipped.
  task automatic send_frame(input int bad_lane, input int bad_beat, input int nbeats,
                            input bit with_last);
    logic [CH-1:0][7:0] v;
    for (int k = 0; k < nbeats; k++) begin
      for (int l = 0; l < CH; l++) begin
        v[l] = msg[k];
        if (l == bad_lane && k == bad_beat) v[l] = v[l] ^ 8'h40;
      end
      check("in_ready_acc", 64'(b1.in_ready), 64'h1);
      b1.in_data  = v;
      b1.in_valid = 1'b1;
      b1.in_last  = with_last && (k == nbeats - 1);
      cyc();
    end
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
  endtask

  task automatic finish_vote();
    check("vote_in_ready", 64'(b1.in_ready), 64'h0);
    check("vote_out_valid", 64'(b1.out_valid), 64'h0);
    cyc();
    check("hold_out_valid", 64'(b1.out_valid), 64'h1);
  endtask

  task automatic handshake();
    b1.out_ready = 1'b1;
    cyc();
    b1.out_ready = 1'b0;
    check("post_hs_in_ready", 64'(b1.in_ready), 64'h1);
    check("post_hs_out_valid", 64'(b1.out_valid), 64'h0);
  endtask

  initial begin
    for (int k = 0; k < 9; k++) msg[k] = 8'h31 + 8'(k);
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0; b1.fault_clr = 1'b0;
    b2.in_valid = 1'b0; b2.in_last = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0; b2.fault_clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    check("rst_in_ready", 64'(b1.in_ready), 64'h1);
    check("rst_out_valid", 64'(b1.out_valid), 64'h0);
    check("rst_out_crc", 64'(b1.out_crc), 64'h0);
    check("rst_out_err", 64'(b1.out_err), 64'h0);
    check("rst_unc", 64'(b1.out_uncorrectable), 64'h0);
    check("rst_mismatch", 64'(b1.ch_mismatch), 64'h0);
    check("rst_fault", 64'(b1.ch_fault), 64'h0);
    check("rst_err_cnt", 64'(b1.err_cnt), 64'h0);

    // Clean frame
    send_frame(-1, -1, 9, 1'b1);
    finish_vote();
    check("s1_crc", 64'(b1.out_crc), 64'hF7);
    check("s1_err", 64'(b1.out_err), 64'h0);
    check("s1_mismatch", 64'(b1.ch_mismatch), 64'h0);
    check("s1_unc", 64'(b1.out_uncorrectable), 64'h0);
    handshake();

    // Lane 1, byte 5 corrupted
    send_frame(1, 4, 9, 1'b1);
    finish_vote();
    check("s2_crc", 64'(b1.out_crc), 64'hF7);
    check("s2_err", 64'(b1.out_err), 64'h1);
    check("s2_mismatch", 64'(b1.ch_mismatch), 64'h2);
    check("s2_unc", 64'(b1.out_uncorrectable), 64'h0);
    check("s2_err_cnt", 64'(b1.err_cnt), 64'h000100);
    handshake();

    // Consumer stalls for 5 cycles
    send_frame(-1, -1, 9, 1'b1);
    finish_vote();
    for (int s = 0; s < 5; s++) begin
      check("s3_hold_valid", 64'(b1.out_valid), 64'h1);
      check("s3_hold_in_ready", 64'(b1.in_ready), 64'h0);
      check("s3_hold_crc", 64'(b1.out_crc), 64'hF7);
      check("s3_hold_err", 64'(b1.out_err), 64'h0);
      cyc();
    end
    handshake();

    // Four consecutive lane-2 mismatches raise its fault
    for (int f = 1; f <= 4; f++) begin
      send_frame(2, 0, 9, 1'b1);
      finish_vote();
      check("s4_crc", 64'(b1.out_crc), 64'hF7);
      check("s4_mismatch", 64'(b1.ch_mismatch), 64'h4);
      check("s4_fault", 64'(b1.ch_fault), (f == 4) ? 64'h4 : 64'h0);
      handshake();
    end
    check("s4_err_cnt", 64'(b1.err_cnt), 64'h040100);
    b1.fault_clr = 1'b1;
    cyc();
    b1.fault_clr = 1'b0;
    check("s4_clr_fault", 64'(b1.ch_fault), 64'h0);
    check("s4_clr_err_cnt", 64'(b1.err_cnt), 64'h040100);
    send_frame(2, 3, 9, 1'b1);
    finish_vote();
    check("s4_after_clr_fault", 64'(b1.ch_fault), 64'h0);
    check("s4_after_clr_err_cnt", 64'(b1.err_cnt), 64'h050100);
    handshake();

    // Zero preset, single-beat frame, every lane different
    b2.in_data  = {8'h02, 8'h01, 8'h00};
    b2.in_valid = 1'b1;
    b2.in_last  = 1'b1;
    cyc();
    b2.in_valid = 1'b0;
    b2.in_last  = 1'b0;
    check("s5_vote_valid", 64'(b2.out_valid), 64'h0);
    cyc();
    check("s5_valid", 64'(b2.out_valid), 64'h1);
    check("s5_crc", 64'(b2.out_crc), 64'h20);
    check("s5_mismatch", 64'(b2.ch_mismatch), 64'h7);
    check("s5_unc", 64'(b2.out_uncorrectable), 64'h1);
    check("s5_err", 64'(b2.out_err), 64'h1);
    check("s5_err_cnt", 64'(b2.err_cnt), 64'h010101);

    // Reset in the middle of a frame
    send_frame(-1, -1, 3, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("s6_in_ready", 64'(b1.in_ready), 64'h1);
    check("s6_out_valid", 64'(b1.out_valid), 64'h0);
    check("s6_err_cnt", 64'(b1.err_cnt), 64'h0);
    send_frame(-1, -1, 9, 1'b1);
    finish_vote();
    check("s6_crc", 64'(b1.out_crc), 64'hF7);
    check("s6_mismatch", 64'(b1.ch_mismatch), 64'h0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
